// File: rtl/irq_trap_ctrl.sv
// rtl/irq_trap_ctrl.sv - interrupt trap sequencer: pick, wait for commit, flush, CSR update.
// Optional saturating trap counter enabled by IRQ_TAKEN_CNT_EN.
module irq_trap_ctrl #(
  parameter int XLEN    = 32,
  parameter int PC_SIZE = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               irq_i_tmr_int,
  input  logic               irq_i_sft_int,
  input  logic               irq_i_ext_int,
  input  logic               irq_i_mtie,
  input  logic               irq_i_msie,
  input  logic               irq_i_meie,
  input  logic               irq_i_mstatus_mie,
  input  logic [XLEN-1:0]    irq_i_mtvec,
  input  logic               irq_i_cmt_valid,
  input  logic [PC_SIZE-1:0] irq_i_cmt_pc,
  input  logic               irq_i_cmt_len4,
  input  logic               irq_i_bjp_req_flush,
  input  logic [PC_SIZE-1:0] irq_i_bjp_target,
  input  logic               irq_i_flush_ack,
  output logic               irq_o_flush_req,
  output logic [PC_SIZE-1:0] irq_o_flush_pc,
  output logic               irq_o_csr_wen,
  output logic [PC_SIZE-1:0] irq_o_mepc,
  output logic [XLEN-1:0]    irq_o_mcause,
  output logic               irq_o_busy,
  output logic [31:0]        irq_o_taken_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT_CMT, FLUSH, UPDATE} state_t;
  state_t state;

  logic [2:0]         pend;
  logic [3:0]         code;
  logic [XLEN-1:0]    mcause_next;
  logic [XLEN-1:0]    mtvec_base;
  logic [XLEN-1:0]    vec_addr;
  logic [PC_SIZE-1:0] ret_pc;
  logic [PC_SIZE-1:0] mepc_raw;
  logic [PC_SIZE-1:0] mepc_next;
  logic [PC_SIZE-1:0] flush_pc_next;

  assign pend = {3{irq_i_mstatus_mie}} &
                {irq_i_ext_int & irq_i_meie, irq_i_sft_int & irq_i_msie, irq_i_tmr_int & irq_i_mtie};

  always_comb begin
    code = 4'd7;
    if (pend[2])      code = 4'd11;
    else if (pend[1]) code = 4'd3;
  end

  assign mcause_next = {1'b1, {(XLEN-5){1'b0}}, code};
  assign mtvec_base  = {irq_i_mtvec[XLEN-1:2], 2'b00};
  assign vec_addr    = (irq_i_mtvec[1:0] == 2'b01) ? mtvec_base + (XLEN'(code) << 2) : mtvec_base;
  assign flush_pc_next = PC_SIZE'(vec_addr);

  // A taken branch at the trap point resumes at its target after mret.
  assign ret_pc    = irq_i_cmt_pc + (irq_i_cmt_len4 ? PC_SIZE'(4) : PC_SIZE'(2));
  assign mepc_raw  = irq_i_bjp_req_flush ? irq_i_bjp_target : ret_pc;
  assign mepc_next = {mepc_raw[PC_SIZE-1:1], 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      irq_o_flush_req <= 1'b0;
      irq_o_flush_pc  <= '0;
      irq_o_csr_wen   <= 1'b0;
      irq_o_mepc      <= '0;
      irq_o_mcause    <= '0;
      irq_o_busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pend != 3'b000) begin
            state      <= WAIT_CMT;
            irq_o_busy <= 1'b1;
          end
        end
        WAIT_CMT: begin
          if (pend == 3'b000) begin
            state      <= IDLE;
            irq_o_busy <= 1'b0;
          end else if (irq_i_cmt_valid) begin
            state           <= FLUSH;
            irq_o_flush_req <= 1'b1;
            irq_o_flush_pc  <= flush_pc_next;
            irq_o_mepc      <= mepc_next;
            irq_o_mcause    <= mcause_next;
          end
        end
        FLUSH: begin
          if (irq_i_flush_ack) begin
            state           <= UPDATE;
            irq_o_flush_req <= 1'b0;
            irq_o_csr_wen   <= 1'b1;
          end
        end
        UPDATE: begin
          state         <= IDLE;
          irq_o_csr_wen <= 1'b0;
          irq_o_busy    <= 1'b0;
        end
        default: begin
          state           <= IDLE;
          irq_o_flush_req <= 1'b0;
          irq_o_csr_wen   <= 1'b0;
          irq_o_busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef IRQ_TAKEN_CNT_EN
  logic [31:0] taken_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt <= '0;
    end else if (state == UPDATE && taken_cnt != 32'hFFFF_FFFF) begin
      taken_cnt <= taken_cnt + 32'd1;
    end
  end

  assign irq_o_taken_cnt = taken_cnt;
`else
  assign irq_o_taken_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_irq_trap_ctrl.sv
// tb/tb_irq_trap_ctrl.sv - directed self-checking bench for irq_trap_ctrl.
module tb_irq_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        irq_i_tmr_int, irq_i_sft_int, irq_i_ext_int;
  logic        irq_i_mtie, irq_i_msie, irq_i_meie, irq_i_mstatus_mie;
  logic [31:0] irq_i_mtvec;
  logic        irq_i_cmt_valid;
  logic [31:0] irq_i_cmt_pc;
  logic        irq_i_cmt_len4;
  logic        irq_i_bjp_req_flush;
  logic [31:0] irq_i_bjp_target;
  logic        irq_i_flush_ack;
  logic        irq_o_flush_req;
  logic [31:0] irq_o_flush_pc;
  logic        irq_o_csr_wen;
  logic [31:0] irq_o_mepc;
  logic [31:0] irq_o_mcause;
  logic        irq_o_busy;
  logic [31:0] irq_o_taken_cnt;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] exp_cnt  = 32'd0;

  irq_trap_ctrl #(.XLEN(32), .PC_SIZE(32)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .irq_i_tmr_int       (irq_i_tmr_int),
    .irq_i_sft_int       (irq_i_sft_int),
    .irq_i_ext_int       (irq_i_ext_int),
    .irq_i_mtie          (irq_i_mtie),
    .irq_i_msie          (irq_i_msie),
    .irq_i_meie          (irq_i_meie),
    .irq_i_mstatus_mie   (irq_i_mstatus_mie),
    .irq_i_mtvec         (irq_i_mtvec),
    .irq_i_cmt_valid     (irq_i_cmt_valid),
    .irq_i_cmt_pc        (irq_i_cmt_pc),
    .irq_i_cmt_len4      (irq_i_cmt_len4),
    .irq_i_bjp_req_flush (irq_i_bjp_req_flush),
    .irq_i_bjp_target    (irq_i_bjp_target),
    .irq_i_flush_ack     (irq_i_flush_ack),
    .irq_o_flush_req     (irq_o_flush_req),
    .irq_o_flush_pc      (irq_o_flush_pc),
    .irq_o_csr_wen       (irq_o_csr_wen),
    .irq_o_mepc          (irq_o_mepc),
    .irq_o_mcause        (irq_o_mcause),
    .irq_o_busy          (irq_o_busy),
    .irq_o_taken_cnt     (irq_o_taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".flush_req"}, {31'd0, irq_o_flush_req}, 32'd0);
    check({tag, ".csr_wen"},   {31'd0, irq_o_csr_wen},   32'd0);
    check({tag, ".busy"},      {31'd0, irq_o_busy},      32'd0);
    check({tag, ".flush_pc"},  irq_o_flush_pc,           32'd0);
    check({tag, ".mepc"},      irq_o_mepc,               32'd0);
    check({tag, ".mcause"},    irq_o_mcause,             32'd0);
    check({tag, ".taken_cnt"}, irq_o_taken_cnt,          32'd0);
  endtask

  task automatic check_trap(input string tag, input logic [31:0] fpc,
                            input logic [31:0] mepc, input logic [31:0] mcause);
    check({tag, ".flush_req"}, {31'd0, irq_o_flush_req}, 32'd1);
    check({tag, ".csr_wen"},   {31'd0, irq_o_csr_wen},   32'd0);
    check({tag, ".flush_pc"},  irq_o_flush_pc,           fpc);
    check({tag, ".mepc"},      irq_o_mepc,               mepc);
    check({tag, ".mcause"},    irq_o_mcause,             mcause);
  endtask

  // Ack the flush, then model the CSR file clearing MIE on the edge ending UPDATE.
  task automatic finish_trap(input string tag);
    irq_i_cmt_valid     = 1'b0;
    irq_i_bjp_req_flush = 1'b0;
    irq_i_flush_ack     = 1'b1;
    tick();
    check({tag, ".upd_flush_req"}, {31'd0, irq_o_flush_req}, 32'd0);
    check({tag, ".upd_csr_wen"},   {31'd0, irq_o_csr_wen},   32'd1);
    check({tag, ".upd_busy"},      {31'd0, irq_o_busy},      32'd1);
    irq_i_flush_ack   = 1'b0;
    irq_i_mstatus_mie = 1'b0;
    tick();
`ifdef IRQ_TAKEN_CNT_EN
    exp_cnt = exp_cnt + 32'd1;
`endif
    check({tag, ".end_csr_wen"}, {31'd0, irq_o_csr_wen}, 32'd0);
    check({tag, ".end_busy"},    {31'd0, irq_o_busy},    32'd0);
    check({tag, ".taken_cnt"},   irq_o_taken_cnt,        exp_cnt);
    tick();
    check({tag, ".no_retrigger"}, {31'd0, irq_o_busy}, 32'd0);
    irq_i_tmr_int = 1'b0;
    irq_i_sft_int = 1'b0;
    irq_i_ext_int = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    irq_i_tmr_int = 1'b0; irq_i_sft_int = 1'b0; irq_i_ext_int = 1'b0;
    irq_i_mtie = 1'b0; irq_i_msie = 1'b0; irq_i_meie = 1'b0;
    irq_i_mstatus_mie = 1'b0;
    irq_i_mtvec = 32'h0;
    irq_i_cmt_valid = 1'b0; irq_i_cmt_pc = 32'h0; irq_i_cmt_len4 = 1'b0;
    irq_i_bjp_req_flush = 1'b0; irq_i_bjp_target = 32'h0;
    irq_i_flush_ack = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Timer only, direct mode.
    irq_i_tmr_int = 1'b1; irq_i_mtie = 1'b1; irq_i_mstatus_mie = 1'b1;
    irq_i_mtvec = 32'h200;
    tick();
    check("t1.busy", {31'd0, irq_o_busy}, 32'd1);
    check("t1.wait_flush_req", {31'd0, irq_o_flush_req}, 32'd0);
    irq_i_cmt_valid = 1'b1; irq_i_cmt_pc = 32'h100; irq_i_cmt_len4 = 1'b1;
    tick();
    check_trap("t1", 32'h200, 32'h104, 32'h8000_0007);
    finish_trap("t1");

    // All three pending, vectored; commit coincident with pend rise is ignored.
    irq_i_mstatus_mie = 1'b1;
    irq_i_tmr_int = 1'b1; irq_i_sft_int = 1'b1; irq_i_ext_int = 1'b1;
    irq_i_mtie = 1'b1; irq_i_msie = 1'b1; irq_i_meie = 1'b1;
    irq_i_mtvec = 32'h201;
    irq_i_cmt_valid = 1'b1; irq_i_cmt_pc = 32'h40; irq_i_cmt_len4 = 1'b0;
    tick();
    check("t2.busy", {31'd0, irq_o_busy}, 32'd1);
    check("t2.same_cycle_commit", {31'd0, irq_o_flush_req}, 32'd0);
    tick();
    check_trap("t2", 32'h22C, 32'h42, 32'h8000_000B);
    finish_trap("t2");

    // Commit on a taken branch: mepc takes the branch target.
    irq_i_mstatus_mie = 1'b1; irq_i_tmr_int = 1'b1;
    irq_i_msie = 1'b0; irq_i_meie = 1'b0;
    irq_i_mtvec = 32'h200;
    tick();
    irq_i_cmt_valid = 1'b1; irq_i_cmt_pc = 32'h300; irq_i_cmt_len4 = 1'b1;
    irq_i_bjp_req_flush = 1'b1; irq_i_bjp_target = 32'h800;
    tick();
    check_trap("t3", 32'h200, 32'h800, 32'h8000_0007);
    finish_trap("t3");

    // External raised then dropped before commit; commit in the drop cycle is ignored.
    irq_i_mstatus_mie = 1'b1; irq_i_ext_int = 1'b1; irq_i_meie = 1'b1;
    tick();
    check("t4.busy", {31'd0, irq_o_busy}, 32'd1);
    irq_i_ext_int = 1'b0;
    irq_i_cmt_valid = 1'b1; irq_i_cmt_pc = 32'h500;
    tick();
    check("t4.idle_busy", {31'd0, irq_o_busy}, 32'd0);
    check("t4.idle_flush_req", {31'd0, irq_o_flush_req}, 32'd0);
    irq_i_cmt_valid = 1'b0;
    tick();
    check("t4.flush_req", {31'd0, irq_o_flush_req}, 32'd0);
    check("t4.csr_wen", {31'd0, irq_o_csr_wen}, 32'd0);
    check("t4.busy_after", {31'd0, irq_o_busy}, 32'd0);

    // Ack withheld, inputs churn during FLUSH; mepc wraps past 2^32.
    irq_i_ext_int = 1'b1; irq_i_mtvec = 32'h201;
    tick();
    irq_i_cmt_valid = 1'b1; irq_i_cmt_pc = 32'hFFFF_FFFC; irq_i_cmt_len4 = 1'b1;
    tick();
    check_trap("t5.f1", 32'h22C, 32'h0, 32'h8000_000B);
    for (int i = 1; i <= 5; i++) begin
      irq_i_ext_int = i[0];
      irq_i_cmt_valid = 1'b1; irq_i_cmt_pc = 32'h1234;
      irq_i_mtvec = 32'h300;
      irq_i_bjp_req_flush = 1'b1; irq_i_bjp_target = 32'hABC;
      tick();
      check_trap($sformatf("t5.hold%0d", i), 32'h22C, 32'h0, 32'h8000_000B);
    end
    finish_trap("t5");

    // Reset asserted in the third FLUSH cycle clears outputs immediately.
    irq_i_mstatus_mie = 1'b1; irq_i_tmr_int = 1'b1; irq_i_meie = 1'b0;
    irq_i_mtvec = 32'h200;
    tick();
    irq_i_cmt_valid = 1'b1; irq_i_cmt_pc = 32'h100; irq_i_cmt_len4 = 1'b1;
    tick();
    irq_i_cmt_valid = 1'b0;
    tick();
    tick();
    check("t6.flush_req_c3", {31'd0, irq_o_flush_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    exp_cnt = 32'd0;
    check_reset_outputs("t6.async_reset");
    irq_i_tmr_int = 1'b0; irq_i_mstatus_mie = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("t6.post_csr_wen", {31'd0, irq_o_csr_wen}, 32'd0);
    check("t6.post_flush_req", {31'd0, irq_o_flush_req}, 32'd0);
    check("t6.post_busy", {31'd0, irq_o_busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
